// File: rtl/servant_serdes.sv
// Serial framed word transceiver: start bit, WIDTH data bits, stop bit, one bit per wb_clk.
// The TX path shifts words onto o_data. The RX path assembles words from i_data into a first-word-fall-through FIFO.
module servant_serdes #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter bit LSB_FIRST = 1
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic             i_data,
    output logic             o_data,
    input  logic [WIDTH-1:0] i_tx_dat,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_dat,
    output logic             o_rx_valid,
    input  logic             i_rx_ready,
    output logic             o_overflow,
    output logic             o_frame_err,
    input  logic             i_clr_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    // state    | meaning
    // TX_IDLE  | line high, ready for a word
    // TX_START | start bit on line
    // TX_DATA  | data bits on line
    // TX_STOP  | stop bit on line, may accept next word
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    // RX_IDLE  | hunting for start bit
    // RX_DATA  | sampling data bits
    // RX_STOP  | checking stop bit
    // RX_BREAK | line stuck low, wait for a 1
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    tx_state_t        tx_state;
    logic [WIDTH-1:0] tx_shift;
    logic [CW-1:0]    tx_cnt;
    logic             tx_accept;
    logic             tx_bit;
    logic [WIDTH-1:0] tx_shifted;

    assign tx_accept  = i_tx_valid && o_tx_ready;
    assign tx_bit     = LSB_FIRST ? tx_shift[0] : tx_shift[WIDTH-1];
    assign tx_shifted = LSB_FIRST ? (tx_shift >> 1) : (tx_shift << 1);

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            tx_state   <= TX_IDLE;
            tx_shift   <= '0;
            tx_cnt     <= '0;
            o_data     <= 1'b1;
            o_tx_ready <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE, TX_STOP: begin
                    if (tx_accept) begin
                        tx_shift   <= i_tx_dat;
                        o_data     <= 1'b0;
                        o_tx_ready <= 1'b0;
                        tx_state   <= TX_START;
                    end else begin
                        o_data     <= 1'b1;
                        o_tx_ready <= 1'b1;
                        tx_state   <= TX_IDLE;
                    end
                end
                TX_START: begin
                    o_data   <= tx_bit;
                    tx_shift <= tx_shifted;
                    tx_cnt   <= CW'(1);
                    tx_state <= TX_DATA;
                end
                default: begin
                    if (tx_cnt == CNT_FULL) begin
                        o_data     <= 1'b1;
                        o_tx_ready <= 1'b1;
                        tx_state   <= TX_STOP;
                    end else begin
                        o_data   <= tx_bit;
                        tx_shift <= tx_shifted;
                        tx_cnt   <= tx_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    rx_state_t        rx_state;
    logic [WIDTH-1:0] rx_shift;
    logic [CW-1:0]    rx_cnt;
    logic [WIDTH-1:0] rx_shift_in;
    logic             rx_push;
    logic             rx_bad_stop;

    assign rx_shift_in = LSB_FIRST ? {i_data, rx_shift[WIDTH-1:1]} : {rx_shift[WIDTH-2:0], i_data};
    assign rx_push     = (rx_state == RX_STOP) && i_data;
    assign rx_bad_stop = (rx_state == RX_STOP) && !i_data;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rx_state <= RX_BREAK;
            rx_shift <= '0;
            rx_cnt   <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (!i_data) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    rx_shift <= rx_shift_in;
                    rx_cnt   <= rx_cnt + CW'(1);
                    if (rx_cnt == CNT_LAST) rx_state <= RX_STOP;
                end
                RX_STOP:  rx_state <= i_data ? RX_IDLE : RX_BREAK;
                default:  if (i_data) rx_state <= RX_IDLE;
            endcase
        end
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             empty, full, pop, do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop     = !empty && i_rx_ready;
    assign do_push = rx_push && (!full || pop);

    assign o_rx_valid = !empty;
    assign o_rx_dat   = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge wb_clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            o_overflow  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            // A set event in the same cycle as a clear takes priority.
            if (rx_push && full && !pop) o_overflow <= 1'b1;
            else if (i_clr_err)          o_overflow <= 1'b0;
            if (rx_bad_stop)             o_frame_err <= 1'b1;
            else if (i_clr_err)          o_frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_servant_serdes.sv
// Scoreboard bench for servant_serdes. Expected words and line bits are queued at issue time.
// A negedge monitor pops and compares these queued values against what the DUT presents.
module tb_servant_serdes;

    localparam int W = 32;
    localparam int D = 4;

    logic wb_clk = 1'b0;
    logic wb_rst_n = 1'b1;
    always #5 wb_clk = ~wb_clk;

    logic         o_data;
    logic         loop_en = 1'b1;
    logic         tb_line = 1'b1;
    wire          line_in = loop_en ? o_data : tb_line;
    logic [W-1:0] tx_dat = '0;
    logic         tx_valid = 1'b0;
    logic         o_tx_ready;
    logic [W-1:0] o_rx_dat;
    logic         o_rx_valid;
    logic         rdy_mode = 1'b0;
    logic         rdy_val = 1'b0;
    logic         rnd_bit = 1'b1;
    wire          rx_ready = rdy_mode ? rnd_bit : rdy_val;
    logic         o_overflow, o_frame_err;
    logic         clr_err = 1'b0;

    servant_serdes #(.WIDTH(W), .DEPTH(D), .LSB_FIRST(1)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .i_data(line_in), .o_data(o_data),
        .i_tx_dat(tx_dat), .i_tx_valid(tx_valid), .o_tx_ready(o_tx_ready),
        .o_rx_dat(o_rx_dat), .o_rx_valid(o_rx_valid), .i_rx_ready(rx_ready),
        .o_overflow(o_overflow), .o_frame_err(o_frame_err), .i_clr_err(clr_err)
    );

    logic [7:0] m_tx_dat = '0;
    logic       m_tx_valid = 1'b0;
    logic       m_tx_ready;
    wire        m_line;
    logic [7:0] m_rx_dat;
    logic       m_rx_valid;
    logic       m_rx_ready = 1'b1;
    logic       m_ovf, m_ferr;
    logic       m_clr = 1'b0;

    servant_serdes #(.WIDTH(8), .DEPTH(2), .LSB_FIRST(0)) u_msb (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .i_data(m_line), .o_data(m_line),
        .i_tx_dat(m_tx_dat), .i_tx_valid(m_tx_valid), .o_tx_ready(m_tx_ready),
        .o_rx_dat(m_rx_dat), .o_rx_valid(m_rx_valid), .i_rx_ready(m_rx_ready),
        .o_overflow(m_ovf), .o_frame_err(m_ferr), .i_clr_err(m_clr)
    );

    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           acc_last = -1;
    int           acc_prev = -1;
    logic [W-1:0] sb_q[$];
    logic         line_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge wb_clk) begin
        cyc     <= cyc + 1;
        rnd_bit <= ($urandom_range(3) != 0);
    end

    // Monitor: line shape, accept bookkeeping, received words.
    always @(negedge wb_clk) begin
        if (wb_rst_n) begin
            if (line_q.size() > 0) check("tx_line", o_data, line_q.pop_front());
            else                   check("tx_idle", o_data, 1);
            if (tx_valid && o_tx_ready) begin
                line_q.push_back(1'b0);
                for (int i = 0; i < W; i++) line_q.push_back(tx_dat[i]);
                line_q.push_back(1'b1);
                if (loop_en) sb_q.push_back(tx_dat);
                acc_prev = acc_last;
                acc_last = cyc + 1;
            end
            if (o_rx_valid && rx_ready) begin
                if (sb_q.size() == 0) check("rx_unexpected", 1, 0);
                else                  check("rx_word", o_rx_dat, sb_q.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] w, input bit keep);
        int t;
        tx_dat   = w;
        tx_valid = 1'b1;
        t = 0;
        do begin
            @(negedge wb_clk);
            t++;
        end while (!o_tx_ready && t < 200);
        if (!o_tx_ready) check("tx_accept_timeout", 0, 1);
        @(posedge wb_clk);
        #1;
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        rdy_val = 1'b1;
        while ((sb_q.size() != 0 || o_rx_valid) && t < 400) begin
            @(negedge wb_clk);
            #1;
            t++;
        end
        check("drain_done", (sb_q.size() == 0 && !o_rx_valid), 1);
        @(posedge wb_clk);
        #1;
        rdy_val = 1'b0;
    endtask

    task automatic inject(input logic [W-1:0] w, input bit stop, input bit pop_at_stop,
                          input bit clr_at_stop, input int hold0);
        if (stop && (sb_q.size() < D || pop_at_stop)) sb_q.push_back(w);
        @(posedge wb_clk);
        #1 tb_line = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(posedge wb_clk);
            #1 tb_line = w[i];
        end
        @(posedge wb_clk);
        #1 tb_line = stop;
        if (pop_at_stop) rdy_val = 1'b1;
        if (clr_at_stop) clr_err = 1'b1;
        @(posedge wb_clk);
        #1;
        rdy_val = 1'b0;
        clr_err = 1'b0;
        if (hold0 > 0) begin
            tb_line = 1'b0;
            repeat (hold0) @(posedge wb_clk);
            #1;
        end
        tb_line = 1'b1;
    endtask

    task automatic pulse_clr();
        @(posedge wb_clk);
        #1 clr_err = 1'b1;
        @(posedge wb_clk);
        #1 clr_err = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           t;
        logic [W-1:0] words [5];
        logic [9:0]   exp_m;

        #1 wb_rst_n = 1'b0;
        #2;
        check("rst_o_data", o_data, 1);
        check("rst_tx_ready", o_tx_ready, 1);
        check("rst_rx_valid", o_rx_valid, 0);
        check("rst_rx_dat", o_rx_dat, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_frame_err", o_frame_err, 0);
        repeat (2) @(posedge wb_clk);
        #1 wb_rst_n = 1'b1;
        @(posedge wb_clk);
        #1;

        // Loopback latency and data
        rdy_val = 1'b1;
        send(32'hDEADBEEF, 0);
        t = 0;
        @(negedge wb_clk);
        while (!o_rx_valid && t < 100) begin
            @(negedge wb_clk);
            t++;
        end
        check("rx_latency", t, 34);
        check("rx_deadbeef", o_rx_dat, 32'hDEADBEEF);
        drain();

        // Back-to-back with valid held
        send(32'h00000001, 1);
        send(32'h80000000, 0);
        check("b2b_spacing", 64'(acc_last - acc_prev), 34);
        drain();

        // Random words, random gaps, random rx_ready
        rdy_mode = 1'b1;
        for (int n = 0; n < 20; n++) begin
            send($urandom, 0);
            repeat ($urandom_range(0, 3)) @(posedge wb_clk);
            #1;
        end
        rdy_mode = 1'b0;
        drain();
        check("rand_no_overflow", o_overflow, 0);
        check("rand_no_frame_err", o_frame_err, 0);

        // Overflow: five frames into a four-deep FIFO with no pops
        loop_en = 1'b0;
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        for (int i = 0; i < 5; i++) inject(words[i], 1, 0, 0, 0);
        @(negedge wb_clk);
        check("ovf_set", o_overflow, 1);
        check("ovf_held_words", sb_q.size(), D);
        check("ovf_oldest", o_rx_dat, words[0]);
        pulse_clr();
        @(negedge wb_clk);
        check("ovf_cleared", o_overflow, 0);
        drain();

        // Pop during the stop-bit cycle of the fifth frame: no overflow
        for (int i = 0; i < 4; i++) inject($urandom, 1, 0, 0, 0);
        inject($urandom, 1, 1, 0, 0);
        @(negedge wb_clk);
        check("pop_at_stop_no_ovf", o_overflow, 0);
        drain();

        // Framing error with clear in the same cycle, break, then recovery
        inject(32'h12345678, 0, 0, 1, 10);
        @(negedge wb_clk);
        check("frame_err_set", o_frame_err, 1);
        check("frame_err_no_push", o_rx_valid, 0);
        inject(32'hA5A5A5A5, 1, 0, 0, 0);
        drain();
        pulse_clr();
        @(negedge wb_clk);
        check("frame_err_cleared", o_frame_err, 0);

        // Reset mid-frame at bit 17
        loop_en = 1'b1;
        @(posedge wb_clk);
        #1;
        send(32'h13579BDF, 0);
        repeat (18) @(posedge wb_clk);
        #1 wb_rst_n = 1'b0;
        sb_q.delete();
        line_q.delete();
        #1;
        check("midrst_o_data", o_data, 1);
        check("midrst_tx_ready", o_tx_ready, 1);
        check("midrst_rx_valid", o_rx_valid, 0);
        repeat (3) @(posedge wb_clk);
        #1 wb_rst_n = 1'b1;
        @(posedge wb_clk);
        #1;
        send(32'h0000FFFF, 0);
        drain();

        // MSB-first, 8-bit instance
        exp_m = 10'b1100000010;
        @(posedge wb_clk);
        #1;
        m_tx_dat   = 8'h81;
        m_tx_valid = 1'b1;
        t = 0;
        do begin
            @(negedge wb_clk);
            t++;
        end while (!m_tx_ready && t < 50);
        check("msb_accept", m_tx_ready, 1);
        @(posedge wb_clk);
        #1 m_tx_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge wb_clk);
            check("msb_line", m_line, exp_m[k]);
        end
        @(negedge wb_clk);
        check("msb_rx_valid", m_rx_valid, 1);
        check("msb_rx_dat", m_rx_dat, 8'h81);
        check("msb_no_ferr", m_ferr, 0);
        check("msb_no_ovf", m_ovf, 0);

        repeat (5) @(posedge wb_clk);
        check("line_q_empty", line_q.size(), 0);
        check("sb_q_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/servant_serdes.md
SERVANT_SERDES -- requirements
Module: servant_serdes

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width, legal 8..64.
REQ-002 SHALL have parameter DEPTH, default 4: RX FIFO depth in words, power of two, >=2.
REQ-003 SHALL have parameter LSB_FIRST, default 1: serial bit order, 1 = bit 0 first, 0 = bit WIDTH-1 first.
REQ-004 SHALL have port wb_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port wb_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_data  in  1  serial RX line, idle high.
REQ-007 SHALL have port o_data  out  1  serial TX line, registered, idle high.
REQ-008 SHALL have ports i_tx_dat  in  WIDTH, i_tx_valid  in  1, o_tx_ready  out  1: TX word handshake.
REQ-009 SHALL have ports o_rx_dat  out  WIDTH, o_rx_valid  out  1, i_rx_ready  in  1: RX word handshake.
REQ-010 SHALL have ports o_overflow  out  1 (sticky), o_frame_err  out  1 (sticky), i_clr_err  in  1 (clears both).

Function
REQ-011 SHALL use frame format: one start bit 0, WIDTH data bits in LSB_FIRST order, one stop bit 1, one bit per wb_clk cycle.
REQ-012 SHALL implement RX FSM with states IDLE, DATA, STOP, BREAK and a bit counter of clog2(WIDTH+1) bits.
REQ-013 RX IDLE: i_data sampled 0 -> DATA, counter cleared; sampled 1 -> stay.
REQ-014 RX DATA: shift in i_data each cycle; after WIDTH samples -> STOP.
REQ-015 RX STOP: i_data 1 -> push assembled word to FIFO, -> IDLE; i_data 0 -> word discarded, o_frame_err set, -> BREAK.
REQ-016 RX BREAK: stay until i_data sampled 1, then -> IDLE; no start bit is detected while in BREAK.
REQ-017 SHALL provide first-word-fall-through FIFO: o_rx_valid = not empty, o_rx_dat = oldest word; pop on o_rx_valid && i_rx_ready.
REQ-018 Push into a full FIFO with no pop that cycle: word dropped, FIFO unchanged, o_overflow set at that edge.
REQ-019 Simultaneous push and pop when full: both performed, no overflow; when empty, pushed word becomes visible next cycle (no bypass).
REQ-020 FIFO pointers SHALL be clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full/empty from pointer MSB compare.
REQ-021 SHALL implement TX FSM with states IDLE, START, DATA, STOP; o_tx_ready high in IDLE and STOP only.
REQ-022 TX accept on i_tx_valid && o_tx_ready: latch i_tx_dat, -> START; o_data = 0 for one cycle.
REQ-023 TX DATA: o_data carries WIDTH bits, one per cycle, in LSB_FIRST order, then -> STOP (o_data = 1).
REQ-024 TX STOP: accept -> START next cycle (back-to-back period WIDTH+2 cycles); else -> IDLE, o_data stays 1.
REQ-025 i_tx_dat/i_tx_valid changes while o_tx_ready = 0 SHALL have no effect.
REQ-026 i_clr_err clears o_overflow and o_frame_err; a set event in the same cycle SHALL win.
REQ-027 Loopback latency: o_rx_valid rises 34 edges after TX accept edge for WIDTH=32, FIFO empty (WIDTH+2 generally).

Reset
REQ-028 wb_rst_n low SHALL asynchronously force: o_data 1, o_tx_ready 1, o_rx_valid 0, o_rx_dat 0, o_overflow 0, o_frame_err 0, FIFO empty, TX FSM IDLE, RX FSM BREAK.
REQ-029 Reset mid-frame SHALL abort both FSMs; partial words discarded; RX needs one sampled 1 after release before detecting a start bit.
REQ-030 Reset release SHALL be effective at the first wb_clk edge with wb_rst_n high; no output changes before that edge.

Verification
REQ-031 Loopback o_data->i_data, send 0xDEADBEEF (WIDTH=32, LSB_FIRST=1) -> o_rx_dat 0xDEADBEEF, o_rx_valid high 34 edges after accept.
REQ-032 Back-to-back TX of 0x00000001, 0x80000000 with i_tx_valid held -> accepts 34 cycles apart, line shows 0,1,0x31,1,0,0x31,1 with final 1 (MSB last), both received in order.
REQ-033 i_rx_ready held 0, inject 5 valid frames, DEPTH=4 -> first 4 words retained, 5th dropped, o_overflow 1; pop in stop-bit cycle of 5th frame -> no overflow.
REQ-034 Inject frame 0x12345678 with stop bit 0, line held 0 for 10 cycles, then 1 -> o_frame_err 1, no push, next valid frame 0xA5A5A5A5 received.
REQ-035 Assert wb_rst_n low at bit 17 of a TX frame -> o_data 1 immediately, no RX word; after release, 0x0000FFFF sent and received intact.
REQ-036 LSB_FIRST=0, WIDTH=8, send 0x81 -> line bits after start: 1,0,0,0,0,0,0,1; o_rx_dat 0x81.
